// File: rtl/sky_keypad_pkg.sv
// Shared types and constants for the keypad scanner.
package sky_keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_EVAL = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CL_NONE  = 2'd0,
        CL_KEY   = 2'd1,
        CL_MULTI = 2'd2
    } class_e;

    // Indexed by frame bit position 4*col + row.
    localparam logic [KEY_W-1:0] KEYMAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,   // column 0, rows 0..3
        4'h2, 4'h5, 4'h8, 4'hF,   // column 1
        4'h3, 4'h6, 4'h9, 4'hE,   // column 2
        4'hA, 4'hB, 4'hC, 4'hD    // column 3
    };

endpackage

// File: rtl/sky_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module sky_sync2 #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two register stages; the first may go metastable, the second is used.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sky_keypad.sv
// 4x4 matrix keypad scanner: column drive, frame capture, classification,
// frame-level debounce and key commit with a one-cycle strobe.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_SCAN | drive one column low, sample its rows at end of dwell
//   ST_EVAL | classify the captured 16-bit frame and update debounce
module sky_keypad
    import sky_keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DEB_TARGET = 4'(DEBOUNCE);

    logic [3:0]       row_sync;

    state_e           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [15:0]      frame_q, frame_d;
    class_e           prev_class_q, prev_class_d;
    logic [KEY_W-1:0] prev_code_q, prev_code_d;
    logic [3:0]       count_q, count_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic [1:0]       ones;
    logic [3:0]       hit_idx;
    class_e           frame_class;
    logic [KEY_W-1:0] frame_code;
    logic             same_class;

    sky_sync2 #(
        .W       (4),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk_i (system1000),
        .rst_i (system1000_rst),
        .d_i   (row),
        .q_o   (row_sync)
    );

    // Classify the captured frame: count set bits (saturating at 2) and
    // remember the position of a set bit for the single-key case.
    always_comb begin
        ones    = 2'd0;
        hit_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_q[i]) begin
                hit_idx = 4'(i);
                if (ones != 2'd2) begin
                    ones = ones + 2'd1;
                end
            end
        end
        case (ones)
            2'd0:    frame_class = CL_NONE;
            2'd1:    frame_class = CL_KEY;
            default: frame_class = CL_MULTI;
        endcase
        frame_code = KEYMAP[hit_idx];
        // Two KEY frames only match when they carry the same code.
        same_class = (frame_class == prev_class_q) &&
                     ((frame_class != CL_KEY) || (frame_code == prev_code_q));
    end

    // Next-state logic: column scan, frame capture and debounce/commit.
    always_comb begin
        state_d      = state_q;
        col_idx_d    = col_idx_q;
        dwell_d      = dwell_q;
        frame_d      = frame_q;
        prev_class_d = prev_class_q;
        prev_code_d  = prev_code_q;
        count_d      = count_q;
        key_d        = key_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;

        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    frame_d[{col_idx_q, 2'b00} +: 4] = ~row_sync;
                    // Wraps to 0 after column 3, so EVAL already drives column 0.
                    col_idx_d = col_idx_q + 2'd1;
                    if (col_idx_q == 2'd3) begin
                        state_d = ST_EVAL;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end

            ST_EVAL: begin
                state_d      = ST_SCAN;
                prev_class_d = frame_class;
                prev_code_d  = frame_code;

                if (frame_class == CL_MULTI) begin
                    count_d = 4'd0;
                end else if (same_class) begin
                    count_d = (count_q >= DEB_TARGET) ? DEB_TARGET : count_q + 4'd1;
                end else begin
                    count_d = 4'd1;
                end

                // A stable frame is re-committed every EVAL once saturated;
                // the held/code check keeps a steady key from re-strobing.
                if ((frame_class != CL_MULTI) && (count_d == DEB_TARGET)) begin
                    if (frame_class == CL_KEY) begin
                        if (!key_held_q || (frame_code != key_q)) begin
                            key_d       = frame_code;
                            key_held_d  = 1'b1;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        key_held_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // State register with asynchronous reset to the idle scan position.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q      <= ST_SCAN;
            col_idx_q    <= 2'd0;
            dwell_q      <= '0;
            frame_q      <= 16'h0000;
            prev_class_q <= CL_NONE;
            prev_code_q  <= '0;
            count_q      <= 4'd0;
            key_q        <= '0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_idx_q    <= col_idx_d;
            dwell_q      <= dwell_d;
            frame_q      <= frame_d;
            prev_class_q <= prev_class_d;
            prev_code_q  <= prev_code_d;
            count_q      <= count_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign col       = ~(4'b0001 << col_idx_q);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: doc/sky_keypad.md
# sky_keypad

Scanning receiver for a 4x4 matrix keypad (PmodKYPD layout), the input-side counterpart of the seven-segment/anode output driver in the `sky` top level. It drives one column low at a time and samples the four row lines. It debounces whole scan frames and emits a 4-bit hex key code with a one-cycle strobe. The machine core consumes the code, and it can be echoed on the display.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled; must be ≥ 4.
- DEBOUNCE, 4: consecutive identical frames required to commit a press or release; range 1–15.

Ports:
- system1000  in  1  clock; all state on its rising edge.
- system1000_rst  in  1  reset, asynchronous, active-high.
- row  in  4  keypad rows, active-low, externally pulled up; asynchronous to system1000.
- col  out  4  keypad columns, active-low, exactly one bit low at any time.
- key  out  4  last committed key code; holds its value until the next commit.
- key_valid  out  1  one-cycle pulse when key is updated.
- key_held  out  1  high while the committed key remains pressed.

## Operation
- row passes through a 2-flop synchronizer before use.
- FSM states:
  - SCAN: column index c (0..3) and a dwell counter 0..SCAN_DIV-1. col = ~(1<<c). On dwell = SCAN_DIV-1, sample ~row_sync into frame bits [4c+3:4c], then c++. After c=3, go to EVAL.
  - EVAL: one cycle. Classify the 16-bit frame, then return to SCAN with c=0.
- Frame classification:
  - NONE: zero bits set.
  - KEY(code): exactly one bit set.
  - MULTI: two or more bits set.
- Keymap (row r, col c → code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce in EVAL. Keep prev_class and a stable count that saturates at DEBOUNCE.
  - If class equals prev_class, count++; otherwise count = 1.
  - MULTI always forces count = 0 and never commits.
- Commit when count reaches DEBOUNCE:
  - KEY(code), and (key_held=0 or code≠key): key←code, key_held←1, key_valid pulses in the following cycle.
  - NONE: key_held←0, key unchanged, no key_valid.
  - A stable repeat of the committed key produces no further pulses; there is no auto-repeat.
- Rolling from one key to another without a release commits the new code once it is stable.

## Timing
- Reset values: col=4'b1110, key=0, key_valid=0, key_held=0, FSM=SCAN, c=0, dwell=0, prev_class=NONE, count=0, synchronizer flops=1111.
- Frame period = 4·SCAN_DIV + 1 cycles.
- Sampling at the end of the dwell gives SCAN_DIV-1 cycles of column settling before each sample.
- Latency from a clean press to key_valid: at most (DEBOUNCE+1) frame periods + 3 cycles (2 synchronizer + 1 register). Release-to-key_held-low has the same bound.
- key_valid is never high on two consecutive cycles. key is stable whenever key_valid=1.
- Reset asserted mid-scan or mid-EVAL forces every output to its reset value immediately (asynchronously). Scanning restarts at column 0 on the first edge after deassertion.

## Structure
- Shared package sky_keypad_pkg holds:
  - the state enum (SCAN, EVAL);
  - the class enum (NONE, KEY, MULTI);
  - the 16-entry keymap constant;
  - the key code width constant (4).
- One sub-module, sky_sync2: a 2-flop synchronizer, 4 bits wide, reset value 1111.
- Scan, classify and debounce logic stay in sky_keypad.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=2, so one frame is 17 cycles. The bench keypad model pulls row bit r low while col bit c is low for each pressed key.
- Reset and free run: after reset, col sequence 1110, 1101, 1011, 0111, each held 4 cycles, then 1 EVAL cycle with col=1110. key=0, key_valid=0, key_held=0 throughout.
- Single press of r2/c1 held for 5 frames: exactly one key_valid pulse with key=8, no later than 3 frames + 3 cycles after press onset; key_held=1. After release, key_held=0 within 3 frames + 3 cycles and key stays 8.
- Bounce: r0/c3 toggled every 3 cycles for 2 frames, then held: no strobe during the bounce; one strobe with key=A after it settles.
- Two keys (r0/c0 and r1/c1) held together: no key_valid, key_held unchanged. Releasing r1/c1 leaves only r0/c0, which commits key=1.
- Roll-over: hold 5 (r1/c1) to commit, then press 9 (r2/c2) and release 5 without a NONE frame in between: second strobe with key=9, key_held stays 1.
- Reset mid-scan: assert system1000_rst at column 2 while key=D is held. Outputs return immediately to col=1110, key=0, key_held=0. After deassertion, D re-commits after DEBOUNCE frames.
